// File: rtl/inst_pair_queue_pkg.sv
// Shared constants and helpers for the dual-width fetch-to-decode instruction queue.
package inst_pair_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  typedef enum logic [1:0] {
    PopNone = 2'd0,
    PopOne  = 2'd1,
    PopTwo  = 2'd2
  } pop_req_e;

  function automatic pop_req_e pop_request(input logic pop, input logic pop_single);
    if (!pop) return PopNone;
    if (pop_single) return PopOne;
    return PopTwo;
  endfunction

endpackage

// File: rtl/inst_pair_queue_if.sv
// Fetch-push / issue-pop bundle of the instruction pair queue; directions named from the queue side.
interface inst_pair_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic            flush_i;
  logic            push0_valid_i;
  logic [31:0]     push0_inst_i;
  logic [31:0]     push0_pc_i;
  logic            push1_valid_i;
  logic [31:0]     push1_inst_i;
  logic [31:0]     push1_pc_i;
  logic            ready_o;
  logic            pop_i;
  logic            pop_single_i;
  logic            head0_valid_o;
  logic [31:0]     head0_inst_o;
  logic [31:0]     head0_pc_o;
  logic            head1_valid_o;
  logic [31:0]     head1_inst_o;
  logic [31:0]     head1_pc_o;
  logic [CntW-1:0] count_o;

  modport slave (
    input  flush_i, push0_valid_i, push0_inst_i, push0_pc_i,
    input  push1_valid_i, push1_inst_i, push1_pc_i, pop_i, pop_single_i,
    output ready_o, head0_valid_o, head0_inst_o, head0_pc_o,
    output head1_valid_o, head1_inst_o, head1_pc_o, count_o
  );

  modport master (
    output flush_i, push0_valid_i, push0_inst_i, push0_pc_i,
    output push1_valid_i, push1_inst_i, push1_pc_i, pop_i, pop_single_i,
    input  ready_o, head0_valid_o, head0_inst_o, head0_pc_o,
    input  head1_valid_o, head1_inst_o, head1_pc_o, count_o
  );

endinterface

// File: rtl/inst_pair_ram.sv
// Depth x 64 queue storage: two writes at consecutive addresses, two asynchronous reads.
module inst_pair_ram #(
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we0_i,
  input  logic             we1_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [63:0]      wdata0_i,
  input  logic [63:0]      wdata1_i,
  input  logic [AddrW-1:0] raddr0_i,
  input  logic [AddrW-1:0] raddr1_i,
  output logic [63:0]      rdata0_o,
  output logic [63:0]      rdata1_o
);

  logic [63:0]      mem_q [Depth];
  logic [AddrW-1:0] waddr1;

  assign waddr1 = waddr_i + AddrW'(1);

  always_ff @(posedge clk_i) begin
    if (we0_i) mem_q[waddr_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1]  <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_pair_queue.sv
// Dual-width instruction queue: up to two pushes and two pops per cycle, two oldest entries shown.
module inst_pair_queue
  import inst_pair_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input logic          clock_i,
  input logic          reset_i,
  inst_pair_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, rd_ptr1;
  logic [CntW-1:0] count_q, count_d;
  logic            ready;
  logic            push_ok;
  logic [1:0]      push_cnt, pop_req, pop_eff;
  logic [63:0]     rdata0, rdata1;

  // Registered count only: a same-cycle pop never frees space for this cycle's push.
  assign ready    = count_q <= CntW'(DEPTH - 2);
  assign push_ok  = bus.push0_valid_i & ready & ~bus.flush_i;
  assign push_cnt = {1'b0, push_ok} + {1'b0, push_ok & bus.push1_valid_i};
  assign pop_req  = pop_request(bus.pop_i, bus.pop_single_i);
  assign pop_eff  = (count_q >= CntW'(pop_req)) ? pop_req : count_q[1:0];

  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop_eff);
    wr_ptr_d = wr_ptr_q + PtrW'(push_cnt);
    count_d  = count_q - CntW'(pop_eff) + CntW'(push_cnt);
    if (bus.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_ptr1 = rd_ptr_q + PtrW'(1);

  inst_pair_ram #(
    .Depth (DEPTH)
  ) u_ram (
    .clk_i    (clock_i),
    .we0_i    (push_ok),
    .we1_i    (push_ok & bus.push1_valid_i),
    .waddr_i  (wr_ptr_q),
    .wdata0_i ({bus.push0_inst_i, bus.push0_pc_i}),
    .wdata1_i ({bus.push1_inst_i, bus.push1_pc_i}),
    .raddr0_i (rd_ptr_q),
    .raddr1_i (rd_ptr1),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  always_comb begin
    bus.ready_o       = ready;
    bus.count_o       = count_q;
    bus.head0_valid_o = count_q != '0;
    bus.head1_valid_o = count_q >= CntW'(2);
    bus.head0_inst_o  = bus.head0_valid_o ? rdata0[63:32] : NOP_INST;
    bus.head0_pc_o    = bus.head0_valid_o ? rdata0[31:0]  : '0;
    bus.head1_inst_o  = bus.head1_valid_o ? rdata1[63:32] : NOP_INST;
    bus.head1_pc_o    = bus.head1_valid_o ? rdata1[31:0]  : '0;
  end

  push_needs_ready_a: assert property (@(posedge clock_i) disable iff (reset_i)
    (bus.push0_valid_i && !bus.flush_i) |-> bus.ready_o);

endmodule

// File: tb/tb_inst_pair_queue.sv
// Directed bench for inst_pair_queue: fill, drain, steady stream, wrap, flush and async reset.
module tb_inst_pair_queue;
  import inst_pair_queue_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  int unsigned n_vec   = 0;
  int unsigned n_miss  = 0;

  inst_pair_queue_if #(.DEPTH(DEPTH)) q_if ();

  inst_pair_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (q_if.slave)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    q_if.flush_i       = 1'b0;
    q_if.push0_valid_i = 1'b0;
    q_if.push1_valid_i = 1'b0;
    q_if.push0_inst_i  = '0;
    q_if.push0_pc_i    = '0;
    q_if.push1_inst_i  = '0;
    q_if.push1_pc_i    = '0;
    q_if.pop_i         = 1'b0;
    q_if.pop_single_i  = 1'b0;
  endtask

  // One clock with the given traffic; word 1 carries pc0+4. Inputs drop to idle afterwards.
  task automatic cycle(input logic p0, input logic p1, input logic [31:0] pc0,
                       input logic pop, input logic single, input logic flush);
    q_if.push0_valid_i = p0;
    q_if.push1_valid_i = p1;
    q_if.push0_pc_i    = pc0;
    q_if.push0_inst_i  = inst_of(pc0);
    q_if.push1_pc_i    = pc0 + 32'd4;
    q_if.push1_inst_i  = inst_of(pc0 + 32'd4);
    q_if.pop_i         = pop;
    q_if.pop_single_i  = single;
    q_if.flush_i       = flush;
    @(posedge clock_i);
    #1;
    idle_inputs();
  endtask

  task automatic check_state(input string tag, input int cnt, input logic rdy);
    check_eq({tag, ".count"}, 32'(q_if.count_o), 32'(cnt));
    check_eq({tag, ".ready"}, 32'(q_if.ready_o), 32'(rdy));
  endtask

  task automatic check_heads(input string tag, input logic v0, input logic [31:0] pc0,
                             input logic v1, input logic [31:0] pc1);
    check_eq({tag, ".h0v"}, 32'(q_if.head0_valid_o), 32'(v0));
    check_eq({tag, ".h0pc"}, q_if.head0_pc_o, v0 ? pc0 : 32'h0);
    check_eq({tag, ".h0inst"}, q_if.head0_inst_o, v0 ? inst_of(pc0) : 32'h0000_0013);
    check_eq({tag, ".h1v"}, 32'(q_if.head1_valid_o), 32'(v1));
    check_eq({tag, ".h1pc"}, q_if.head1_pc_o, v1 ? pc1 : 32'h0);
    check_eq({tag, ".h1inst"}, q_if.head1_inst_o, v1 ? inst_of(pc1) : 32'h0000_0013);
  endtask

  initial begin
    idle_inputs();
    #12;
    check_state("rst", 0, 1'b1);
    check_heads("rst", 1'b0, 0, 1'b0, 0);
    @(negedge clock_i);
    reset_i = 1'b0;

    // Fill with four dual pushes; heads visible one cycle after the first push.
    cycle(1, 1, 32'h00, 0, 0, 0);
    check_state("fill1", 2, 1'b1);
    check_heads("fill1", 1'b1, 32'h0, 1'b1, 32'h4);
    cycle(1, 1, 32'h08, 0, 0, 0);
    cycle(1, 1, 32'h10, 0, 0, 0);
    check_state("fill3", 6, 1'b1);
    cycle(1, 1, 32'h18, 0, 0, 0);
    check_state("fill4", 8, 1'b0);
    check_heads("fill4", 1'b1, 32'h0, 1'b1, 32'h4);

    // Dual pops down to four, then single pops.
    cycle(0, 0, 0, 1, 0, 0);
    check_state("pop2a", 6, 1'b1);
    check_heads("pop2a", 1'b1, 32'h08, 1'b1, 32'h0C);
    cycle(0, 0, 0, 1, 0, 0);
    check_state("pop2b", 4, 1'b1);
    cycle(0, 0, 0, 1, 1, 0);
    check_state("pop1a", 3, 1'b1);
    check_heads("pop1a", 1'b1, 32'h14, 1'b1, 32'h18);
    cycle(0, 0, 0, 1, 1, 0);
    check_state("pop1b", 2, 1'b1);
    check_heads("pop1b", 1'b1, 32'h18, 1'b1, 32'h1C);

    // Steady stream: push two, pop two; heads move 8 bytes per cycle.
    cycle(1, 1, 32'h20, 1, 0, 0);
    check_state("steady1", 2, 1'b1);
    check_heads("steady1", 1'b1, 32'h20, 1'b1, 32'h24);
    cycle(1, 1, 32'h28, 1, 0, 0);
    check_state("steady2", 2, 1'b1);
    check_heads("steady2", 1'b1, 32'h28, 1'b1, 32'h2C);

    // Drain, then walk both pointers to 7; includes a dual pop at count 1.
    cycle(0, 0, 0, 1, 0, 0);
    check_state("drain", 0, 1'b1);
    check_heads("drain", 1'b0, 0, 1'b0, 0);
    cycle(1, 0, 32'h30, 0, 0, 0);
    check_state("single", 1, 1'b1);
    check_heads("single", 1'b1, 32'h30, 1'b0, 0);
    cycle(1, 1, 32'h34, 1, 0, 0);
    check_state("pop2cnt1", 2, 1'b1);
    check_heads("pop2cnt1", 1'b1, 32'h34, 1'b1, 32'h38);
    cycle(0, 0, 0, 1, 0, 0);
    check_state("at7", 0, 1'b1);

    // rd_ptr = wr_ptr = 7: dual push lands in entries 7 and 0.
    cycle(1, 1, 32'h100, 0, 0, 0);
    check_state("wrap", 2, 1'b1);
    check_heads("wrap", 1'b1, 32'h100, 1'b1, 32'h104);

    // Build count 5, then flush alongside a push and a pop.
    cycle(1, 1, 32'h108, 0, 0, 0);
    cycle(1, 0, 32'h110, 0, 0, 0);
    check_state("pre_flush", 5, 1'b1);
    check_heads("pre_flush", 1'b1, 32'h100, 1'b1, 32'h104);
    cycle(1, 1, 32'h1F0, 1, 0, 1);
    check_state("flush", 0, 1'b1);
    check_heads("flush", 1'b0, 0, 1'b0, 0);
    cycle(1, 1, 32'h200, 0, 0, 0);
    check_state("post_flush", 2, 1'b1);
    check_heads("post_flush", 1'b1, 32'h200, 1'b1, 32'h204);

    // Async reset between clock edges.
    reset_i = 1'b1;
    #1;
    check_state("async_rst", 0, 1'b1);
    check_heads("async_rst", 1'b0, 0, 1'b0, 0);
    @(negedge clock_i);
    reset_i = 1'b0;
    cycle(0, 0, 0, 0, 0, 0);
    check_state("after_rst", 0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
